scs8hd_clkdiv_gen: RTL and testbench

//   Programmable divide-by-N clock generator. Produces a registered, glitch-free divided clock
//   (CLKOUT) that directly drives scs8hd_clkinv_2 clock-tree inverters downstream.

---
 rtl/scs8hd_clkdiv_gen.sv | 116 +++++++++++
 tb/tb_scs8hd_clkdiv_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_clkdiv_gen.sv
// Programmable divide-by-N clock generator with a registered, glitch-free CLKOUT.
// Supports clean EN start/stop and a 4-phase divisor update handshake.
//
//   state | meaning
//   IDLE  | CLKOUT parked low, counter held at 0
//   RUN   | generating periods, EN high
//   STOP  | EN dropped mid-period; finishing the current period unchanged
module scs8hd_clkdiv_gen #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             EN,
    input  logic             DIV_REQ,
    input  logic [CNT_W-1:0] DIV_VAL,
    output logic             DIV_ACK,
    output logic             CLKOUT,
    output logic             TICK,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div_reg, div_nxt;
    logic [CNT_W-1:0] hi_len;
    logic             clkout_nxt;
    logic             tick_nxt;
    logic             ack_nxt;
    logic             end_of_period;
    logic             accept;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

    // ceil(N/2) without needing a wider adder
    assign hi_len        = (div_reg >> 1) + {{(CNT_W-1){1'b0}}, div_reg[0]};
    assign end_of_period = (state != IDLE) && (cnt == div_reg - CNT_W'(1));
    assign accept        = DIV_REQ && !DIV_ACK && ((state == IDLE) || end_of_period);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        clkout_nxt = 1'b0;
        tick_nxt   = 1'b0;
        div_nxt    = div_reg;
        ack_nxt    = DIV_ACK;

        if (accept) begin
            div_nxt = clamp_div(DIV_VAL);
            ack_nxt = 1'b1;
        end else if (!DIV_REQ) begin
            ack_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (EN) begin
                    state_nxt  = RUN;
                    clkout_nxt = 1'b1;
                    tick_nxt   = 1'b1;
                end
            end
            RUN, STOP: begin
                if (end_of_period) begin
                    if (EN) begin
                        state_nxt  = RUN;
                        clkout_nxt = 1'b1;
                        tick_nxt   = 1'b1;
                    end else begin
                        state_nxt  = IDLE;
                    end
                end else begin
                    // a period in flight always completes, EN only picks the label
                    cnt_nxt    = cnt + CNT_W'(1);
                    clkout_nxt = (cnt_nxt < hi_len);
                    state_nxt  = EN ? RUN : STOP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state   <= IDLE;
            cnt     <= '0;
            div_reg <= RST_DIV;
            CLKOUT  <= 1'b0;
            TICK    <= 1'b0;
            DIV_ACK <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_reg <= div_nxt;
            CLKOUT  <= clkout_nxt;
            TICK    <= tick_nxt;
            DIV_ACK <= ack_nxt;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_scs8hd_clkdiv_gen.sv
// Directed bench for scs8hd_clkdiv_gen: start/stop, divisor handshake, clamping, reset.
module tb_scs8hd_clkdiv_gen;

    logic       CLK;
    logic       RESETB;
    logic       EN;
    logic       DIV_REQ;
    logic [7:0] DIV_VAL;
    logic       DIV_ACK;
    logic       CLKOUT;
    logic       TICK;
    logic       BUSY;

    int n_asserts = 0;
    int n_fail    = 0;

    scs8hd_clkdiv_gen #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
        .CLK     (CLK),
        .RESETB  (RESETB),
        .EN      (EN),
        .DIV_REQ (DIV_REQ),
        .DIV_VAL (DIV_VAL),
        .DIV_ACK (DIV_ACK),
        .CLKOUT  (CLKOUT),
        .TICK    (TICK),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts just after a period-start edge; checks one full period and leaves
    // the bench just after the following edge.
    task automatic run_period(input string tag, input int n, input int hi);
        for (int j = 0; j < n; j++) begin
            chk({tag, "_clk"},  CLKOUT, (j < hi));
            chk({tag, "_tick"}, TICK,   (j == 0));
            chk({tag, "_busy"}, BUSY,   1'b1);
            step();
        end
    endtask

    initial begin
        RESETB = 1'b0; EN = 1'b0; DIV_REQ = 1'b0; DIV_VAL = 8'd0;
        step(); step();
        chk("rst_clk", CLKOUT, 1'b0);
        chk("rst_tick", TICK, 1'b0);
        chk("rst_ack", DIV_ACK, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        RESETB = 1'b1;
        step();
        chk("idle_busy", BUSY, 1'b0);

        // 1: default N=2
        EN = 1'b1;
        step();
        run_period("t1a", 2, 1);
        run_period("t1b", 2, 1);

        // stop from the high phase: one low cycle, then idle
        EN = 1'b0;
        step();
        chk("t1_stop_clk", CLKOUT, 1'b0);
        chk("t1_stop_busy", BUSY, 1'b1);
        step();
        chk("t1_idle_clk", CLKOUT, 1'b0);
        chk("t1_idle_busy", BUSY, 1'b0);

        // 2: program N=5 in idle
        DIV_REQ = 1'b1; DIV_VAL = 8'd5;
        chk("t2_ack_pre", DIV_ACK, 1'b0);
        step();
        chk("t2_ack", DIV_ACK, 1'b1);
        chk("t2_idle_clk", CLKOUT, 1'b0);
        chk("t2_idle_busy", BUSY, 1'b0);
        DIV_REQ = 1'b0;
        step();
        chk("t2_ack_fall", DIV_ACK, 1'b0);
        EN = 1'b1;
        step();
        run_period("t2a", 5, 3);
        chk("t2_ack_hold", DIV_ACK, 1'b0);

        // move to N=4: request pending during whole N=5 period, accepted at its wrap
        DIV_REQ = 1'b1; DIV_VAL = 8'd4;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("t3_ack_wait", DIV_ACK, 1'b0);
        end
        step();
        chk("t3_ack4", DIV_ACK, 1'b1);
        DIV_REQ = 1'b0;
        run_period("t3_n4", 4, 2);

        // 3: REQ=6 raised at cnt=1 of an N=4 period
        step();
        chk("t3_c1_clk", CLKOUT, 1'b1);
        DIV_REQ = 1'b1; DIV_VAL = 8'd6;
        step();
        chk("t3_c2_ack", DIV_ACK, 1'b0);
        chk("t3_c2_clk", CLKOUT, 1'b0);
        step();
        chk("t3_c3_ack", DIV_ACK, 1'b0);
        chk("t3_c3_clk", CLKOUT, 1'b0);
        step();
        chk("t3_wrap_ack", DIV_ACK, 1'b1);
        DIV_REQ = 1'b0;
        run_period("t3_n6a", 6, 3);
        run_period("t3_n6b", 6, 3);

        // 4: N=6, drop EN at cnt=1
        step();
        chk("t4_c1_clk", CLKOUT, 1'b1);
        EN = 1'b0;
        step();
        chk("t4_c2_clk", CLKOUT, 1'b1);
        chk("t4_c2_busy", BUSY, 1'b1);
        for (int j = 3; j < 6; j++) begin
            step();
            chk("t4_low_clk", CLKOUT, 1'b0);
            chk("t4_low_tick", TICK, 1'b0);
            chk("t4_low_busy", BUSY, 1'b1);
        end
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t4_park_clk", CLKOUT, 1'b0);
            chk("t4_park_tick", TICK, 1'b0);
            chk("t4_park_busy", BUSY, 1'b0);
        end

        // 5: DIV_VAL=0 in idle clamps to 2
        DIV_REQ = 1'b1; DIV_VAL = 8'd0;
        step();
        chk("t5_ack0", DIV_ACK, 1'b1);
        DIV_REQ = 1'b0;
        step();
        EN = 1'b1;
        step();
        run_period("t5_v0a", 2, 1);
        run_period("t5_v0b", 2, 1);

        // DIV_VAL=1 accepted at a running wrap, also clamps to 2
        DIV_REQ = 1'b1; DIV_VAL = 8'd1;
        step();
        chk("t5_v1_wait", DIV_ACK, 1'b0);
        step();
        chk("t5_ack1", DIV_ACK, 1'b1);
        DIV_REQ = 1'b0;
        run_period("t5_v1a", 2, 1);
        run_period("t5_v1b", 2, 1);

        // DIV_VAL=255: high 128, low 127
        DIV_REQ = 1'b1; DIV_VAL = 8'd255;
        step(); step();
        chk("t5_ack255", DIV_ACK, 1'b1);
        DIV_REQ = 1'b0;
        run_period("t5_n255a", 255, 128);
        for (int j = 0; j < 254; j++) step();
        chk("t5_last_clk", CLKOUT, 1'b0);

        // end of period + new request + EN=0 together: update and go idle
        DIV_REQ = 1'b1; DIV_VAL = 8'd8; EN = 1'b0;
        step();
        chk("t5_eop_busy", BUSY, 1'b0);
        chk("t5_eop_ack", DIV_ACK, 1'b1);
        chk("t5_eop_clk", CLKOUT, 1'b0);
        chk("t5_eop_tick", TICK, 1'b0);
        DIV_REQ = 1'b0;
        step();
        chk("t5_eop_ackfall", DIV_ACK, 1'b0);

        // 6: N=8, reset in the high phase with ACK high
        EN = 1'b1;
        step();
        DIV_REQ = 1'b1; DIV_VAL = 8'd8;
        run_period("t6_n8", 8, 4);
        chk("t6_ack", DIV_ACK, 1'b1);
        step();
        chk("t6_c1_clk", CLKOUT, 1'b1);
        RESETB = 1'b0;
        step();
        chk("t6_rst_clk", CLKOUT, 1'b0);
        chk("t6_rst_ack", DIV_ACK, 1'b0);
        chk("t6_rst_busy", BUSY, 1'b0);
        chk("t6_rst_tick", TICK, 1'b0);
        RESETB = 1'b1; DIV_REQ = 1'b0; EN = 1'b0;
        step();
        chk("t6_idle_clk", CLKOUT, 1'b0);
        EN = 1'b1;
        step();
        run_period("t6_n2a", 2, 1);
        run_period("t6_n2b", 2, 1);

        // request withdrawn before any acceptance point: no ACK, N stays 2
        DIV_REQ = 1'b1; DIV_VAL = 8'd9;
        step();
        DIV_REQ = 1'b0;
        chk("t7_wd_ack1", DIV_ACK, 1'b0);
        step();
        chk("t7_wd_ack2", DIV_ACK, 1'b0);
        run_period("t7_n2", 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
